fetch: RTL and testbench
========================

Name: fetch

Overview:
Instruction-fetch stage, directly upstream of decode. It owns the fetch PC and drives the instruction bus with one outstanding request at a time. Returned words are delivered into the D pipeline register (pc, imp) that decode consumes. It honours decode's branch redirect (ifj/pc_decode) with MIPS delay-slot semantics and holds on decode stalls (pcf1).

Parameters:
RESET_PC, 32'hbfc0_0000, PC of the first fetch after reset.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
ireq_valid  out  1  instruction request valid.
ireq_addr  out  32  request address; equals the fetch PC.
iresp_addr_ok  in  1  request accepted this cycle.
iresp_data_ok  in  1  instruction data returned this cycle.
iresp_data  in  32  returned instruction word.
stall  in  1  D must hold; driven by decode pcf1 OR'd with downstream stalls.
ifj  in  1  decode: the branch in D is taken.
pc_decode  in  32  decode: branch/jump target.
d_valid  out  1  D holds a real instruction.
d_pc  out  32  D.pc.
d_imp  out  32  D.imp, the instruction word.

Behaviour:
- Reset values (synchronous, active-high): state=S_REQ, f_pc=RESET_PC, buffer empty, redirect_pending=0, d_valid=0, d_pc=0, d_imp=0. A reset asserted mid-transaction discards any outstanding request and buffered word. The bus is reset on the same edge, so no stale data_ok follows.
- State S_REQ: ireq_valid=1, ireq_addr=f_pc.
  - addr_ok=0: stay in S_REQ.
  - addr_ok=1, data_ok=0: go to S_WAIT.
  - addr_ok=1, data_ok=1: treat as the data-return case below.
- State S_WAIT: ireq_valid=0.
  - Wait for data_ok.
  - On data_ok with stall=0: deliver the word, then go to S_REQ.
  - On data_ok with stall=1: latch {f_pc, data} into the buffer, then go to S_HOLD.
- State S_HOLD: ireq_valid=0. When stall=0, deliver the buffered word, then go to S_REQ.
- No new request is issued while a fetched word is undelivered. This guarantees the instruction after D is always the next one delivered, which is the delay slot.
- D register:
  - stall=1: D holds all fields.
  - stall=0 with a delivery this cycle: D <= {1, delivered pc, word}.
  - stall=0 with no delivery: D <= {0, 0, 0} (bubble).
- Latency: a word arriving on data_ok with stall=0 is visible on d_* the next cycle. Zero-wait bus throughput is one instruction every 2 cycles (request, then response), or 1 cycle when addr_ok and data_ok coincide.
- Redirect: taken = ifj & d_valid & ~stall. ifj is ignored while stall=1, because forwarded operands are invalid during a load-use stall.
  - taken with a delivery in the same cycle: the delivered word is the delay slot; next f_pc = pc_decode.
  - taken with no delivery that cycle: redirect_pending<=1, redirect_pc<=pc_decode.
  - On the next delivery while redirect_pending=1: next f_pc = redirect_pc; clear redirect_pending.
  - Otherwise next f_pc = delivered pc + 4, wrapping mod 2^32.
- f_pc updates only at delivery; requests use the updated f_pc from the following cycle.
- Branch in the delay slot (architecturally undefined): a newer taken redirect overwrites a pending one.
- The fetch PC is passed to the bus unaligned-as-is. Address exceptions are out of scope.

Decomposition:
- Shared pipeline package (pipeline.svh): existing D_type {pc, imp}, plus new fetch_state_t enum {S_REQ, S_WAIT, S_HOLD} and the RESET_PC constant.
- The ibus request/response fields may be packed into ibus_req_t/ibus_resp_t structs there.
- No sub-module is required. The one-entry holding buffer is small enough to stay inline.

Test Plan:
1. Zero-wait bus (addr_ok and data_ok same cycle as request), stall=0, straight-line code from reset -> d_pc sequence bfc00000, bfc00004, bfc00008 on consecutive cycles; d_valid=0 only in the first cycle after reset.
2. Taken branch at bfc00010 with pc_decode=bfc00100, delay slot returned the same cycle ifj is seen -> D shows bfc00010, then bfc00014, then bfc00100; bfc00018 is never requested.
3. Same branch but delay-slot data_ok delayed 3 cycles -> redirect_pending set; d_valid=0 bubbles; D shows bfc00014, then next ireq_addr=bfc00100.
4. data_ok arrives while stall=1 for 2 cycles -> state S_HOLD, ireq_valid=0, D unchanged; after stall drops, buffered word enters D and the next request goes to pc+4.
5. stall=1 with ifj=1 on a branch, then stall=0 with ifj=1 -> only the unstalled cycle's pc_decode is used; exactly one redirect.
6. reset asserted in S_WAIT with redirect_pending=1 -> next cycle ireq_addr=bfc00000, d_valid=0, pending cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared pipeline types for the fetch stage: the D register layout, fetch FSM
// states and the reset fetch address.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'hbfc0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imp;
    } D_type;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding ibus request, a one-word holding
// buffer for stalls, and MIPS delay-slot redirect handling into the D register.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        ifj,
    input  logic [31:0] pc_decode,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [31:0] d_imp
);

    fetch_state_t r_state;
    logic [31:0]  r_f_pc;
    D_type        r_buf;
    logic         r_redir_pend;
    logic [31:0]  r_redir_pc;
    logic         r_d_valid;
    D_type        r_d;

    logic         w_resp;
    logic         w_deliver;
    logic         w_taken;
    D_type        w_del;
    logic [31:0]  w_next_pc;

    // A word arrives either on the accepting cycle (zero-wait) or later in S_WAIT.
    assign w_resp    = ((r_state == S_REQ) && iresp_addr_ok && iresp_data_ok) ||
                       ((r_state == S_WAIT) && iresp_data_ok);
    assign w_deliver = !stall && (w_resp || (r_state == S_HOLD));
    assign w_del     = (r_state == S_HOLD) ? r_buf : '{pc: r_f_pc, imp: iresp_data};
    assign w_taken   = ifj && r_d_valid && !stall;

    // A same-cycle redirect wins: the word delivered now is the delay slot.
    assign w_next_pc = w_taken      ? pc_decode  :
                       r_redir_pend ? r_redir_pc :
                                      w_del.pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_f_pc       <= RESET_PC;
            r_buf        <= '0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= '0;
            r_d_valid    <= 1'b0;
            r_d          <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (iresp_addr_ok) begin
                        if (iresp_data_ok)
                            r_state <= stall ? S_HOLD : S_REQ;
                        else
                            r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iresp_data_ok)
                        r_state <= stall ? S_HOLD : S_REQ;
                end
                S_HOLD: begin
                    if (!stall)
                        r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase

            if (w_resp && stall)
                r_buf <= '{pc: r_f_pc, imp: iresp_data};

            if (w_deliver) begin
                r_f_pc       <= w_next_pc;
                r_redir_pend <= 1'b0;
            end else if (w_taken) begin
                r_redir_pend <= 1'b1;
                r_redir_pc   <= pc_decode;
            end

            if (!stall) begin
                r_d_valid <= w_deliver;
                r_d       <= w_deliver ? w_del : '0;
            end
        end
    end

    assign ireq_valid = (r_state == S_REQ);
    assign ireq_addr  = r_f_pc;
    assign d_valid    = r_d_valid;
    assign d_pc       = r_d.pc;
    assign d_imp      = r_d.imp;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: straight-line fetch, taken branches with
// immediate and delayed delay slots, stalls, stalled ifj, reset mid-wait, PC wrap.
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stall;
    logic        ifj;
    logic [31:0] pc_decode;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_imp;

    int total = 0;
    int bad   = 0;

    fetch dut (
        .clk          (clk),
        .reset        (reset),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_addr_ok(iresp_addr_ok),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data   (iresp_data),
        .stall        (stall),
        .ifj          (ifj),
        .pc_decode    (pc_decode),
        .d_valid      (d_valid),
        .d_pc         (d_pc),
        .d_imp        (d_imp)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] iw(input logic [31:0] a);
        return a ^ 32'h5a5a_5a5a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, d_valid}, {31'd0, v});
        chk({tag, ".pc"}, d_pc, pc);
        chk({tag, ".imp"}, d_imp, v ? iw(pc) : 32'd0);
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] a);
        iresp_addr_ok = aok;
        iresp_data_ok = dok;
        iresp_data    = iw(a);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; ifj = 1'b0; pc_decode = '0;
        bus(1'b0, 1'b0, 32'd0);
        tick(); tick();
        chk("rst.ireq_valid", {31'd0, ireq_valid}, 32'd1);
        chk("rst.ireq_addr", ireq_addr, 32'hbfc0_0000);
        chk_d("rst.d", 1'b0, 32'd0);
        reset = 1'b0;
        tick();
        chk_d("t1.first", 1'b0, 32'd0);
        chk("t1.addr_ok0_hold", ireq_addr, 32'hbfc0_0000);

        // Straight-line zero-wait fetch
        bus(1'b1, 1'b1, 32'hbfc0_0000); tick();
        chk_d("t1.d0", 1'b1, 32'hbfc0_0000);
        chk("t1.addr4", ireq_addr, 32'hbfc0_0004);
        bus(1'b1, 1'b1, 32'hbfc0_0004); tick();
        chk_d("t1.d4", 1'b1, 32'hbfc0_0004);
        bus(1'b1, 1'b1, 32'hbfc0_0008); tick();
        chk_d("t1.d8", 1'b1, 32'hbfc0_0008);
        bus(1'b1, 1'b1, 32'hbfc0_000c); tick();
        bus(1'b1, 1'b1, 32'hbfc0_0010); tick();
        chk_d("t2.br", 1'b1, 32'hbfc0_0010);
        chk("t2.addr14", ireq_addr, 32'hbfc0_0014);

        // Taken branch, delay slot returned the same cycle
        ifj = 1'b1; pc_decode = 32'hbfc0_0100;
        bus(1'b1, 1'b1, 32'hbfc0_0014); tick();
        chk_d("t2.ds", 1'b1, 32'hbfc0_0014);
        chk("t2.target", ireq_addr, 32'hbfc0_0100);
        ifj = 1'b0; pc_decode = 32'hdead_beef;
        bus(1'b1, 1'b1, 32'hbfc0_0100); tick();
        chk_d("t2.tgt", 1'b1, 32'hbfc0_0100);
        bus(1'b1, 1'b1, 32'hbfc0_0104); tick();
        chk_d("t3.br", 1'b1, 32'hbfc0_0104);

        // Taken branch while the delay slot is still outstanding
        ifj = 1'b1; pc_decode = 32'hbfc0_0200;
        bus(1'b1, 1'b0, 32'h0); tick();
        chk_d("t3.bub1", 1'b0, 32'd0);
        chk("t3.wait_noreq", {31'd0, ireq_valid}, 32'd0);
        ifj = 1'b0; pc_decode = 32'hdead_beef;
        bus(1'b0, 1'b0, 32'h0); tick(); tick();
        chk_d("t3.bub3", 1'b0, 32'd0);
        bus(1'b0, 1'b1, 32'hbfc0_0108); tick();
        chk_d("t3.ds", 1'b1, 32'hbfc0_0108);
        chk("t3.target", ireq_addr, 32'hbfc0_0200);
        chk("t3.req", {31'd0, ireq_valid}, 32'd1);
        bus(1'b1, 1'b1, 32'hbfc0_0200); tick();
        chk_d("t3.tgt", 1'b1, 32'hbfc0_0200);

        // Word returns under stall and waits in the holding buffer
        stall = 1'b1;
        bus(1'b1, 1'b0, 32'h0); tick();
        chk_d("t4.held0", 1'b1, 32'hbfc0_0200);
        bus(1'b0, 1'b1, 32'hbfc0_0204); tick();
        chk_d("t4.held1", 1'b1, 32'hbfc0_0200);
        chk("t4.hold_noreq", {31'd0, ireq_valid}, 32'd0);
        bus(1'b0, 1'b0, 32'h0); tick();
        chk_d("t4.held2", 1'b1, 32'hbfc0_0200);
        chk("t4.hold_noreq2", {31'd0, ireq_valid}, 32'd0);
        stall = 1'b0; tick();
        chk_d("t4.buf", 1'b1, 32'hbfc0_0204);
        chk("t4.next", ireq_addr, 32'hbfc0_0208);
        chk("t4.req", {31'd0, ireq_valid}, 32'd1);

        // ifj under stall is ignored; only the unstalled cycle redirects
        stall = 1'b1; ifj = 1'b1; pc_decode = 32'hbfc0_0f00;
        bus(1'b0, 1'b0, 32'h0); tick();
        chk_d("t5.held", 1'b1, 32'hbfc0_0204);
        chk("t5.addr", ireq_addr, 32'hbfc0_0208);
        stall = 1'b0; pc_decode = 32'hbfc0_0400;
        bus(1'b1, 1'b1, 32'hbfc0_0208); tick();
        chk_d("t5.ds", 1'b1, 32'hbfc0_0208);
        chk("t5.target", ireq_addr, 32'hbfc0_0400);
        ifj = 1'b0;
        bus(1'b1, 1'b1, 32'hbfc0_0400); tick();
        chk_d("t5.tgt", 1'b1, 32'hbfc0_0400);
        chk("t5.once", ireq_addr, 32'hbfc0_0404);

        // Reset while waiting with a redirect pending
        ifj = 1'b1; pc_decode = 32'hbfc0_0500;
        bus(1'b1, 1'b0, 32'h0); tick();
        chk("t6.wait", {31'd0, ireq_valid}, 32'd0);
        ifj = 1'b0; reset = 1'b1;
        bus(1'b0, 1'b0, 32'h0); tick();
        chk("t6.addr", ireq_addr, 32'hbfc0_0000);
        chk("t6.req", {31'd0, ireq_valid}, 32'd1);
        chk_d("t6.d", 1'b0, 32'd0);
        reset = 1'b0;
        bus(1'b1, 1'b1, 32'hbfc0_0000); tick();
        chk_d("t6.d0", 1'b1, 32'hbfc0_0000);
        chk("t6.nopend", ireq_addr, 32'hbfc0_0004);

        // PC wraps modulo 2^32
        ifj = 1'b1; pc_decode = 32'hffff_fffc;
        bus(1'b1, 1'b1, 32'hbfc0_0004); tick();
        chk("t7.top", ireq_addr, 32'hffff_fffc);
        ifj = 1'b0;
        bus(1'b1, 1'b1, 32'hffff_fffc); tick();
        chk_d("t7.d", 1'b1, 32'hffff_fffc);
        chk("t7.wrap", ireq_addr, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
